vga_draw_arbiter: RTL and testbench
===================================

// Module: vga_draw_arbiter
// PURPOSE
//  Shares the vga_example line-draw register port (STAX..MODE, addr 0-6) between NREQ requesters.
//  Round-robin grant; snapshot of the winner's line command; register writes sequenced to the drawer.
//  Issues GO, polls BUSY until the line completes, then pulses done to the winner.
//  Sits between PicoBlaze-side request logic / hardware hand-drawing engines and vga_example, on pclk.
// PARAMETERS
//  NREQ        2      number of requesters (2..4)
//  SYNC_IRQ    0      1 = hold each grant until a vga_irq pulse (draw starts in vertical blank)
//  TIMEOUT     4096   max BUSY-poll cycles before forced completion (must be >= 2)
// PORTS
//  clk            in   1        pixel clock (pclk)
//  reset_n        in   1        asynchronous, active-low reset
//  req            in   NREQ     request level, one bit per requester
//  req_stax       in   8*NREQ   start x; requester i at [8i+7:8i]; same packing for the next four
//  req_stay       in   8*NREQ   start y
//  req_endx       in   8*NREQ   end x
//  req_endy       in   8*NREQ   end y
//  req_beam       in   8*NREQ   beam/colour value
//  gnt            out  NREQ     one-hot, 1-cycle pulse when requester i is granted
//  done           out  NREQ     one-hot, 1-cycle pulse when requester i's line is finished
//  active         out  1        high from grant cycle through the done cycle
//  timeout_err    out  1        sticky; set on a poll timeout, cleared only by reset
//  vga_address    out  3        register address to vga_example
//  vga_write_data out  8        write data to vga_example
//  vga_write      out  1        1-cycle write strobe to vga_example
//  vga_read_data  in   8        combinational read data for vga_address
//  vga_irq        in   1        frame interrupt pulse from vga_example
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, every output 0, rr pointer = NREQ-1 (req 0 highest).
//  States: IDLE -> [WAIT_IRQ] -> W_STAX -> W_STAY -> W_ENDX -> W_ENDY -> W_BEAM -> W_GO
//          -> SETTLE -> POLL -> DONE -> IDLE.
//  IDLE: if any req, winner = first set bit searching upward from rr+1 (wrap mod NREQ).
//    That cycle: gnt[w]=1; all five fields of w latched; rr<=w; next W_STAX, or WAIT_IRQ if SYNC_IRQ.
//  WAIT_IRQ: stays until a vga_irq pulse, then W_STAX. An irq in the grant cycle itself is ignored.
//  W_* states: one cycle each; vga_write=1, addresses 0,1,2,3,5, data = latched field.
//  W_GO: vga_write=1, addr 4 (BUSY), data 8'h01; the drawer starts and sets BUSY.
//  Write data always comes from the snapshot; req_* may change after gnt without effect.
//  SETTLE: one cycle, vga_address=4, no write; lets the BUSY flag become visible.
//  POLL: vga_address=4; leave when vga_read_data[0]==0; 12-bit count increments each POLL cycle.
//    Count reaching TIMEOUT -> timeout_err<=1, go to DONE anyway.
//  DONE: done[w]=1 for one cycle; active drops on the next edge.
//  Latency: grant -> first vga_write = 1 cycle (no SYNC_IRQ); GO write on cycle grant+6.
//    Minimum grant -> done = 9 cycles (BUSY clear at first POLL).
//  Handshake: requester holds req until it samples done, then drops req on that same edge.
//    req still high in the following IDLE cycle = a new request.
//  req dropped after gnt: command still runs to completion and done still pulses.
//  Round-robin: two continuously requesting masters alternate grants; none is starved.
//  vga_write is never asserted outside the W_* states.
//  vga_address/vga_write_data are registered; 0 in IDLE, WAIT_IRQ and DONE.
//  Reset mid-sequence: immediate IDLE, outputs 0, no done; a partial register set is left in the drawer.
// TESTING
//  1 req=01, stax/stay/endx/endy/beam=10,20,30,40,0F; BUSY low after 3 polls
//    -> gnt=01 at t0; writes (0,10)(1,20)(2,30)(3,40)(5,0F)(4,01) on t0+1..t0+6; done=01 at t0+11.
//  2 req=11 held, fields differ per requester -> grant order 0,1,0,1 over four lines.
//    Each line's writes carry only the granted requester's fields.
//  3 change req_stax right after gnt -> STAX written is the pre-grant value.
//  4 SYNC_IRQ=1, irq 50 cycles after grant -> first vga_write exactly 1 cycle after the irq pulse.
//  5 BUSY stuck at 1, TIMEOUT=16 -> done after 16 POLL cycles; timeout_err=1 and stays 1.
//  6 reset_n low during W_ENDX -> outputs 0 asynchronously; no done.
//    Next req=10 after reset -> granted normally.

Source files
------------

// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter that shares the vga_example line-draw register port between NREQ requesters.
// It writes the winner's command snapshot into STAX..MODE, issues GO, then polls BUSY until the line is drawn.
module vga_draw_arbiter #(
    parameter int NREQ     = 2,
    parameter int SYNC_IRQ = 0,
    parameter int TIMEOUT  = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_stax,
    input  logic [8*NREQ-1:0] req_stay,
    input  logic [8*NREQ-1:0] req_endx,
    input  logic [8*NREQ-1:0] req_endy,
    input  logic [8*NREQ-1:0] req_beam,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              active,
    output logic              timeout_err,
    output logic [2:0]        vga_address,
    output logic [7:0]        vga_write_data,
    output logic              vga_write,
    input  logic [7:0]        vga_read_data,
    input  logic              vga_irq
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT_IRQ,
        S_W_STAX,
        S_W_STAY,
        S_W_ENDX,
        S_W_ENDY,
        S_W_BEAM,
        S_W_GO,
        S_SETTLE,
        S_POLL,
        S_DONE
    } state_t;

    state_t          state, next_state;
    logic [1:0]      rr, win, cand;
    logic            found, any_req, busy, poll_last;
    logic [11:0]     poll_cnt;
    logic [7:0]      snap_stax, snap_stay, snap_endx, snap_endy, snap_beam;
    logic [NREQ-1:0] gnt_nxt, done_nxt;
    logic            active_nxt, err_nxt, write_nxt;
    logic [2:0]      addr_nxt;
    logic [7:0]      data_nxt;
    logic            unused_rd;

    function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
        onehot = NREQ'(1) << idx;
    endfunction

    function automatic logic [7:0] field(input logic [8*NREQ-1:0] bus, input logic [1:0] idx);
        field = 8'(bus >> {idx, 3'b000});
    endfunction

    assign any_req   = |req;
    assign busy      = vga_read_data[0];
    assign unused_rd = ^vga_read_data[7:1];
    // Compare in 13 bits so TIMEOUT = 4096 is reachable by a 12-bit counter.
    assign poll_last = ({1'b0, poll_cnt} + 13'd1) == 13'(TIMEOUT);

    // Search upward from the last winner so a continuous requester cannot starve the others.
    always_comb begin
        win   = rr;
        cand  = rr;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = 2'((int'(rr) + k) % NREQ);
            if (!found && |(req & onehot(cand))) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            rr             <= 2'(NREQ - 1);
            poll_cnt       <= '0;
            gnt            <= '0;
            done           <= '0;
            active         <= 1'b0;
            timeout_err    <= 1'b0;
            vga_address    <= '0;
            vga_write_data <= '0;
            vga_write      <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && any_req)
                rr <= win;
            if (state == S_SETTLE)
                poll_cnt <= '0;
            else if (state == S_POLL)
                poll_cnt <= poll_cnt + 12'd1;
            gnt            <= gnt_nxt;
            done           <= done_nxt;
            active         <= active_nxt;
            timeout_err    <= err_nxt;
            vga_address    <= addr_nxt;
            vga_write_data <= data_nxt;
            vga_write      <= write_nxt;
        end
    end

    // Command snapshot: requesters may change their fields once granted.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && any_req) begin
            snap_stax <= field(req_stax, win);
            snap_stay <= field(req_stay, win);
            snap_endx <= field(req_endx, win);
            snap_endy <= field(req_endy, win);
            snap_beam <= field(req_beam, win);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (any_req) next_state = S_GRANT;
            S_GRANT:    next_state = (SYNC_IRQ != 0) ? S_WAIT_IRQ : S_W_STAX;
            S_WAIT_IRQ: if (vga_irq) next_state = S_W_STAX;
            S_W_STAX:   next_state = S_W_STAY;
            S_W_STAY:   next_state = S_W_ENDX;
            S_W_ENDX:   next_state = S_W_ENDY;
            S_W_ENDY:   next_state = S_W_BEAM;
            S_W_BEAM:   next_state = S_W_GO;
            S_W_GO:     next_state = S_SETTLE;
            S_SETTLE:   next_state = S_POLL;
            S_POLL:     if (!busy || poll_last) next_state = S_DONE;
            S_DONE:     next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Outputs are registered from next_state so the port shows the current phase with no extra lag.
    always_comb begin
        gnt_nxt    = '0;
        done_nxt   = '0;
        active_nxt = (next_state != S_IDLE);
        err_nxt    = timeout_err | (state == S_POLL && busy && poll_last);
        write_nxt  = 1'b0;
        addr_nxt   = 3'd0;
        data_nxt   = 8'h00;
        if (state == S_IDLE && any_req)
            gnt_nxt = onehot(win);
        if (next_state == S_DONE)
            done_nxt = onehot(rr);
        case (next_state)
            S_W_STAX: begin write_nxt = 1'b1; addr_nxt = 3'd0; data_nxt = snap_stax; end
            S_W_STAY: begin write_nxt = 1'b1; addr_nxt = 3'd1; data_nxt = snap_stay; end
            S_W_ENDX: begin write_nxt = 1'b1; addr_nxt = 3'd2; data_nxt = snap_endx; end
            S_W_ENDY: begin write_nxt = 1'b1; addr_nxt = 3'd3; data_nxt = snap_endy; end
            S_W_BEAM: begin write_nxt = 1'b1; addr_nxt = 3'd5; data_nxt = snap_beam; end
            S_W_GO:   begin write_nxt = 1'b1; addr_nxt = 3'd4; data_nxt = 8'h01;     end
            S_SETTLE, S_POLL: addr_nxt = 3'd4;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Bench for vga_draw_arbiter: instance A is checked every cycle against a line-timeline model,
// instance B (SYNC_IRQ=1) is checked with directed expectations around the frame interrupt.
`timescale 1ns/1ps
module tb_vga_draw_arbiter;
    localparam int MAXC = 2000;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [1:0]  req_a = 2'b00;
    logic [15:0] stax_a = '0, stay_a = '0, endx_a = '0, endy_a = '0, beam_a = '0;
    logic [1:0]  gnt_a, done_a;
    logic        active_a, err_a, wr_a;
    logic [2:0]  addr_a;
    logic [7:0]  wdata_a, rdata_a;
    logic        irq_a = 1'b0;

    logic [1:0]  req_b = 2'b00;
    logic [15:0] stax_b = 16'h773C, stay_b = 16'h7722, endx_b = 16'h7733, endy_b = 16'h7744, beam_b = 16'h7755;
    logic [1:0]  gnt_b, done_b;
    logic        active_b, err_b, wr_b;
    logic [2:0]  addr_b;
    logic [7:0]  wdata_b;
    logic [7:0]  rdata_b = 8'h00;
    logic        irq_b = 1'b0;

    vga_draw_arbiter #(.NREQ(2), .SYNC_IRQ(0), .TIMEOUT(TMO)) dut_a (
        .clk(clk), .reset_n(reset_n), .req(req_a),
        .req_stax(stax_a), .req_stay(stay_a), .req_endx(endx_a), .req_endy(endy_a), .req_beam(beam_a),
        .gnt(gnt_a), .done(done_a), .active(active_a), .timeout_err(err_a),
        .vga_address(addr_a), .vga_write_data(wdata_a), .vga_write(wr_a),
        .vga_read_data(rdata_a), .vga_irq(irq_a)
    );

    vga_draw_arbiter #(.NREQ(2), .SYNC_IRQ(1), .TIMEOUT(4096)) dut_b (
        .clk(clk), .reset_n(reset_n), .req(req_b),
        .req_stax(stax_b), .req_stay(stay_b), .req_endx(endx_b), .req_endy(endy_b), .req_beam(beam_b),
        .gnt(gnt_b), .done(done_b), .active(active_b), .timeout_err(err_b),
        .vga_address(addr_b), .vga_write_data(wdata_b), .vga_write(wr_b),
        .vga_read_data(rdata_b), .vga_irq(irq_b)
    );

    // Drawer stand-in: after a GO write, BUSY reads 1 through SETTLE and busy_k POLL cycles.
    int   busy_k = 0;
    int   go_cyc = -1000;
    logic busy_r = 1'b0;
    assign rdata_a = (addr_a == 3'd4) ? {7'd0, busy_r} : 8'h00;
    always @(negedge clk) begin
        if (wr_a && addr_a == 3'd4) go_cyc = cyc;
        busy_r = (cyc >= go_cyc + 1) && (cyc <= go_cyc + 1 + busy_k);
    end

    // Expected outputs of instance A, indexed by cycle number.
    logic [1:0] e_gnt  [MAXC];
    logic [1:0] e_done [MAXC];
    logic       e_act  [MAXC];
    logic       e_err  [MAXC];
    logic       e_wr   [MAXC];
    logic [2:0] e_addr [MAXC];
    logic [7:0] e_data [MAXC];
    int free_from = 0;
    int rr_m = 1;

    task automatic clear_from(input int c);
        for (int i = c; i < MAXC; i++) begin
            e_gnt[i] = '0; e_done[i] = '0; e_act[i] = 1'b0; e_err[i] = 1'b0;
            e_wr[i] = 1'b0; e_addr[i] = '0; e_data[i] = '0;
        end
    endtask

    task automatic put_wr(input int c, input logic [2:0] a, input logic [7:0] d);
        if (c < MAXC) begin e_wr[c] = 1'b1; e_addr[c] = a; e_data[c] = d; end
    endtask

    function automatic logic [7:0] fld(input logic [15:0] bus, input int w);
        fld = bus[8*w +: 8];
    endfunction

    function automatic int pick(input logic [1:0] r, input int last);
        int c;
        c = (last + 1) % 2;
        pick = r[c] ? c : last;
    endfunction

    initial begin
        int w, np, d;
        logic tmo;
        clear_from(0);
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (!reset_n) begin
                clear_from(cyc);
                free_from = cyc;
                rr_m = 1;
            end else if (cyc - 1 >= free_from && req_a != 2'b00) begin
                w = pick(req_a, rr_m);
                rr_m = w;
                e_gnt[cyc] = 2'(1 << w);
                put_wr(cyc + 1, 3'd0, fld(stax_a, w));
                put_wr(cyc + 2, 3'd1, fld(stay_a, w));
                put_wr(cyc + 3, 3'd2, fld(endx_a, w));
                put_wr(cyc + 4, 3'd3, fld(endy_a, w));
                put_wr(cyc + 5, 3'd5, fld(beam_a, w));
                put_wr(cyc + 6, 3'd4, 8'h01);
                tmo = (busy_k >= TMO);
                np  = tmo ? TMO : busy_k + 1;
                for (int i = cyc + 7; i <= cyc + 7 + np && i < MAXC; i++) e_addr[i] = 3'd4;
                d = cyc + 8 + np;
                if (d < MAXC) e_done[d] = 2'(1 << w);
                for (int i = cyc; i <= d && i < MAXC; i++) e_act[i] = 1'b1;
                if (tmo) for (int i = d; i < MAXC; i++) e_err[i] = 1'b1;
                free_from = d + 1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cyc < MAXC) begin
                n_vec++;
                if ({gnt_a, done_a, active_a, err_a, wr_a, addr_a, wdata_a} !==
                    {e_gnt[cyc], e_done[cyc], e_act[cyc], e_err[cyc], e_wr[cyc], e_addr[cyc], e_data[cyc]}) begin
                    n_err++;
                    $display("FAIL model cyc=%0d: got gnt=%b done=%b act=%b err=%b wr=%b addr=%0d data=%h, want gnt=%b done=%b act=%b err=%b wr=%b addr=%0d data=%h",
                             cyc, gnt_a, done_a, active_a, err_a, wr_a, addr_a, wdata_a,
                             e_gnt[cyc], e_done[cyc], e_act[cyc], e_err[cyc], e_wr[cyc], e_addr[cyc], e_data[cyc]);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic wait_gnt_a(output int tg, output int g);
        tg = -1; g = 0;
        for (int i = 0; i < 200 && tg < 0; i++) begin
            tick();
            if (gnt_a != 2'b00) begin tg = cyc; g = int'(gnt_a); end
        end
        if (tg < 0) chk("gnt_a wait expired", 0, 1);
    endtask

    task automatic wait_done_a(output int td, output int dv);
        td = -1; dv = 0;
        for (int i = 0; i < 200 && td < 0; i++) begin
            tick();
            if (done_a != 2'b00) begin td = cyc; dv = int'(done_a); end
        end
        if (td < 0) chk("done_a wait expired", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int tg, td, g, dv, early, tb0;
        int order [4];

        tick(); tick();
        chk("reset outputs A", int'({gnt_a, done_a, active_a, err_a, wr_a, addr_a, wdata_a}), 0);
        chk("reset outputs B", int'({gnt_b, done_b, active_b, err_b, wr_b, addr_b, wdata_b}), 0);
        reset_n = 1'b1;
        tick();

        // Two continuous requesters alternate, starting with requester 0.
        busy_k = 1;
        stax_a = 16'hA111; stay_a = 16'hA212; endx_a = 16'hA313; endy_a = 16'hA414; beam_a = 16'hA515;
        req_a = 2'b11;
        for (int n = 0; n < 4; n++) begin
            wait_gnt_a(tg, g);
            order[n] = g;
            wait_done_a(td, dv);
            chk("rr done matches grant", dv, g);
        end
        req_a = 2'b00;
        chk("rr order 0", order[0], 1);
        chk("rr order 1", order[1], 2);
        chk("rr order 2", order[2], 1);
        chk("rr order 3", order[3], 2);

        // Basic line with BUSY clearing on the third poll.
        tick(); tick();
        busy_k = 2;
        stax_a = 16'h9910; stay_a = 16'h9920; endx_a = 16'h9930; endy_a = 16'h9940; beam_a = 16'h990F;
        req_a = 2'b01;
        wait_gnt_a(tg, g);
        chk("basic gnt", g, 1);
        tick();
        chk("basic STAX write", int'({wr_a, addr_a, wdata_a}), int'({1'b1, 3'd0, 8'h10}));
        repeat (5) tick();
        chk("basic GO write", int'({wr_a, addr_a, wdata_a}), int'({1'b1, 3'd4, 8'h01}));
        wait_done_a(td, dv);
        req_a = 2'b00;
        chk("basic done latency", td - tg, 11);
        chk("basic done vector", dv, 1);

        // Fields changed right after grant must not reach the drawer.
        tick();
        busy_k = 0;
        stax_a = 16'h9955;
        req_a = 2'b01;
        wait_gnt_a(tg, g);
        stax_a = 16'h99AA;
        tick();
        chk("snapshot STAX", int'(wdata_a), 8'h55);
        wait_done_a(td, dv);
        req_a = 2'b00;
        chk("min grant to done", td - tg, 9);

        // BUSY stuck high: forced completion after TMO polls, sticky error.
        tick();
        busy_k = 1000;
        req_a = 2'b10;
        wait_gnt_a(tg, g);
        chk("timeout gnt", g, 2);
        chk("no error before timeout", int'(err_a), 0);
        wait_done_a(td, dv);
        req_a = 2'b00;
        chk("timeout done latency", td - tg, 8 + TMO);
        chk("timeout_err set", int'(err_a), 1);
        repeat (5) tick();
        chk("timeout_err sticky", int'(err_a), 1);

        // Reset in the middle of the register writes.
        busy_k = 2;
        req_a = 2'b01;
        wait_gnt_a(tg, g);
        repeat (3) tick();
        chk("at ENDX write", int'({wr_a, addr_a}), int'({1'b1, 3'd2}));
        reset_n = 1'b0;
        req_a = 2'b00;
        #1;
        chk("async reset outputs", int'({gnt_a, done_a, active_a, err_a, wr_a, addr_a, wdata_a}), 0);
        tick(); tick();
        reset_n = 1'b1;
        early = 0;
        repeat (20) begin tick(); if (done_a != 2'b00) early = 1; end
        chk("no done after reset", early, 0);
        req_a = 2'b10;
        wait_gnt_a(tg, g);
        chk("post-reset gnt", g, 2);
        wait_done_a(td, dv);
        req_a = 2'b00;
        chk("post-reset done latency", td - tg, 11);

        // SYNC_IRQ instance: grant waits for a frame interrupt; grant-cycle irq ignored.
        tick();
        req_b = 2'b01;
        tb0 = -1;
        for (int i = 0; i < 50 && tb0 < 0; i++) begin
            tick();
            if (gnt_b != 2'b00) tb0 = cyc;
        end
        if (tb0 < 0) chk("gnt_b wait expired", 0, 1);
        chk("sync gnt", int'(gnt_b), 1);
        irq_b = 1'b1;
        tick();
        irq_b = 1'b0;
        early = 0;
        while (cyc < tb0 + 50) begin
            if (wr_b) early = 1;
            tick();
        end
        if (wr_b) early = 1;
        chk("sync active while waiting", int'(active_b), 1);
        irq_b = 1'b1;
        tick();
        irq_b = 1'b0;
        chk("sync no write before irq", early, 0);
        chk("sync first write after irq", int'({wr_b, addr_b, wdata_b}), int'({1'b1, 3'd0, 8'h3C}));
        td = -1;
        for (int i = 0; i < 50 && td < 0; i++) begin
            tick();
            if (done_b != 2'b00) td = cyc;
        end
        req_b = 2'b00;
        chk("sync done latency", td - tb0, 59);
        tick(); tick();
        chk("sync idle after done", int'({active_b, wr_b, addr_b}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
